// File: rtl/wb_regfile_pkg.sv
// Shared types for the writeback stage: descriptor, source/load enums, FSM states.
package wb_regfile_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_AW = 5;

  typedef enum logic [1:0] {
    SRC_NOP = 2'd0,
    SRC_ALU = 2'd1,
    SRC_MEM = 2'd2
  } wb_src_t;

  typedef struct packed {
    logic              valid;
    wb_src_t           src;
    logic [DATA_W-1:0] value;
    logic [REG_AW-1:0] dst;
  } write_reg_t;

  typedef enum logic [2:0] {
    LD_B  = 3'd0,
    LD_BU = 3'd1,
    LD_H  = 3'd2,
    LD_HU = 3'd3,
    LD_W  = 3'd4
  } load_kind_t;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_HOLD     = 2'd1,
    ST_WAIT_MEM = 2'd2
  } wb_state_t;

endpackage

// File: rtl/wb_regfile_load_extract.sv
// Pure combinational load-data alignment and sign/zero extension.
module wb_regfile_load_extract
  import wb_regfile_pkg::*;
(
  input  logic [DATA_W-1:0] i_word,
  input  logic [1:0]        i_addr_lo,
  input  load_kind_t        i_kind,
  output logic [DATA_W-1:0] o_value
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Select the addressed byte/half, then extend according to the load kind.
  always_comb begin
    w_byte  = 8'(i_word >> {i_addr_lo, 3'b000});
    w_half  = 16'(i_word >> {i_addr_lo[1], 4'b0000});
    o_value = i_word;
    case (i_kind)
      LD_B:    o_value = {{24{w_byte[7]}}, w_byte};
      LD_BU:   o_value = {24'h000000, w_byte};
      LD_H:    o_value = {{16{w_half[15]}}, w_half};
      LD_HU:   o_value = {16'h0000, w_half};
      default: o_value = i_word;
    endcase
  end

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage: holds one entry, resolves its value, commits to the GPR file,
// and serves two combinational read ports with optional same-cycle bypass.
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int unsigned NUM_REGS  = 32,
  parameter int unsigned BYPASS_EN = 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              in_valid,
  output logic              in_ready,
  input  write_reg_t        in_wr,
  input  logic [DATA_W-1:0] in_alu_result,
  input  load_kind_t        in_load_kind,
  input  logic [1:0]        in_addr_lo,
  input  logic [DATA_W-1:0] in_pc,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_resp_data,
  input  logic [REG_AW-1:0] ra1,
  input  logic [REG_AW-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  output logic [DATA_W-1:0] debug_wb_pc,
  output logic [3:0]        debug_wb_rf_wen,
  output logic [REG_AW-1:0] debug_wb_rf_wnum,
  output logic [DATA_W-1:0] debug_wb_rf_wdata
);

  wb_state_t         r_state;
  wb_state_t         w_state_nxt;
  write_reg_t        r_wr;
  logic [DATA_W-1:0] r_alu;
  load_kind_t        r_kind;
  logic [1:0]        r_addr_lo;
  logic [DATA_W-1:0] r_pc;
  logic [DATA_W-1:0] r_gpr [NUM_REGS];

  logic              w_commit_now;
  logic              w_accept;
  logic              w_wen;
  logic [DATA_W-1:0] w_load_value;
  logic [DATA_W-1:0] w_wdata;

  wb_regfile_load_extract u_load_extract (
    .i_word    (mem_resp_data),
    .i_addr_lo (r_addr_lo),
    .i_kind    (r_kind),
    .o_value   (w_load_value)
  );

  // Handshake: commit frees the slot, so accept and commit may share a cycle.
  always_comb begin
    w_commit_now = (r_state == ST_HOLD) || ((r_state == ST_WAIT_MEM) && mem_resp_valid);
    in_ready     = resetn && ((r_state == ST_IDLE) || w_commit_now);
    w_accept     = in_valid && in_ready;
    w_wen        = resetn && w_commit_now && r_wr.valid && (r_wr.dst != '0);
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!resetn) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  // FSM next state: a new entry wins over returning to idle.
  always_comb begin
    w_state_nxt = r_state;
    if (w_accept) begin
      w_state_nxt = (in_wr.src == SRC_MEM) ? ST_WAIT_MEM : ST_HOLD;
    end else if (w_commit_now) begin
      w_state_nxt = ST_IDLE;
    end
  end

  // Latch the offered entry and its side-band on accept.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_wr      <= '0;
      r_alu     <= '0;
      r_kind    <= LD_W;
      r_addr_lo <= '0;
      r_pc      <= '0;
    end else if (w_accept) begin
      r_wr      <= in_wr;
      r_alu     <= in_alu_result;
      r_kind    <= in_load_kind;
      r_addr_lo <= in_addr_lo;
      r_pc      <= in_pc;
    end
  end

  // Final value for the held entry.
  always_comb begin
    w_wdata = r_wr.value;
    case (r_wr.src)
      SRC_ALU: w_wdata = r_alu;
      SRC_MEM: w_wdata = w_load_value;
      default: w_wdata = r_wr.value;
    endcase
  end

  // GPR array; reset clears every register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_REGS; i++) r_gpr[i] <= '0;
    end else if (w_wen) begin
      r_gpr[r_wr.dst] <= w_wdata;
    end
  end

  // Read ports: r0 is zero, then bypass of the committing value, then the array.
  always_comb begin
    if (ra1 == '0)                                   rd1 = '0;
    else if ((BYPASS_EN != 0) && w_wen && (ra1 == r_wr.dst)) rd1 = w_wdata;
    else                                             rd1 = r_gpr[ra1];
    if (ra2 == '0)                                   rd2 = '0;
    else if ((BYPASS_EN != 0) && w_wen && (ra2 == r_wr.dst)) rd2 = w_wdata;
    else                                             rd2 = r_gpr[ra2];
  end

  // Debug trace of the committing entry.
  always_comb begin
    debug_wb_pc       = r_pc;
    debug_wb_rf_wen   = w_wen ? 4'hF : 4'h0;
    debug_wb_rf_wnum  = r_wr.dst;
    debug_wb_rf_wdata = w_wdata;
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: ALU/load/NOP commits, bypass, r0, invalid entries,
// back-to-back throughput and reset during an outstanding load.
module tb_wb_regfile;
  import wb_regfile_pkg::*;

  logic        clk = 1'b0;
  logic        resetn;
  logic        in_valid;
  logic        in_ready;
  write_reg_t  in_wr;
  logic [31:0] in_alu_result;
  load_kind_t  in_load_kind;
  logic [1:0]  in_addr_lo;
  logic [31:0] in_pc;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic [4:0]  ra1, ra2;
  logic [31:0] rd1, rd2;
  logic [31:0] debug_wb_pc;
  logic [3:0]  debug_wb_rf_wen;
  logic [4:0]  debug_wb_rf_wnum;
  logic [31:0] debug_wb_rf_wdata;

  int n_pass  = 0;
  int n_total = 0;

  wb_regfile #(.NUM_REGS(32), .BYPASS_EN(1)) dut (
    .clk               (clk),
    .resetn            (resetn),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_wr             (in_wr),
    .in_alu_result     (in_alu_result),
    .in_load_kind      (in_load_kind),
    .in_addr_lo        (in_addr_lo),
    .in_pc             (in_pc),
    .mem_resp_valid    (mem_resp_valid),
    .mem_resp_data     (mem_resp_data),
    .ra1               (ra1),
    .ra2               (ra2),
    .rd1               (rd1),
    .rd2               (rd2),
    .debug_wb_pc       (debug_wb_pc),
    .debug_wb_rf_wen   (debug_wb_rf_wen),
    .debug_wb_rf_wnum  (debug_wb_rf_wnum),
    .debug_wb_rf_wdata (debug_wb_rf_wdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic write_reg_t mk(input logic v, input wb_src_t s,
                                    input logic [31:0] val, input logic [4:0] d);
    write_reg_t w;
    w.valid = v;
    w.src   = s;
    w.value = val;
    w.dst   = d;
    return w;
  endfunction

  initial begin
    resetn = 1'b0; in_valid = 1'b0; in_wr = '0; in_alu_result = '0;
    in_load_kind = LD_W; in_addr_lo = '0; in_pc = '0;
    mem_resp_valid = 1'b0; mem_resp_data = '0; ra1 = '0; ra2 = '0;

    // Reset
    tick(); tick();
    check("rst_ready", 32'(in_ready), 32'd0);
    check("rst_wen", 32'(debug_wb_rf_wen), 32'h0);
    resetn = 1'b1; #1;
    check("idle_ready", 32'(in_ready), 32'd1);

    // ALU write to R5
    in_valid = 1'b1; in_wr = mk(1'b1, SRC_ALU, 32'h0, 5'd5);
    in_alu_result = 32'h1234_5678; in_pc = 32'hBFC0_0010;
    tick();
    in_valid = 1'b0; #1;
    check("alu_wen", 32'(debug_wb_rf_wen), 32'hF);
    check("alu_wnum", 32'(debug_wb_rf_wnum), 32'd5);
    check("alu_wdata", debug_wb_rf_wdata, 32'h1234_5678);
    check("alu_pc", debug_wb_pc, 32'hBFC0_0010);
    tick();
    ra1 = 5'd5; #1;
    check("alu_rd1", rd1, 32'h1234_5678);
    check("alu_idle_wen", 32'(debug_wb_rf_wen), 32'h0);

    // LD_B at addr_lo=3 with three cycles of latency
    in_valid = 1'b1; in_wr = mk(1'b1, SRC_MEM, 32'h0, 5'd8);
    in_load_kind = LD_B; in_addr_lo = 2'd3;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("ldb_wait_ready", 32'(in_ready), 32'd0);
      check("ldb_wait_wen", 32'(debug_wb_rf_wen), 32'h0);
      tick();
    end
    mem_resp_valid = 1'b1; mem_resp_data = 32'h80FF_0000; #1;
    check("ldb_ready", 32'(in_ready), 32'd1);
    check("ldb_wen", 32'(debug_wb_rf_wen), 32'hF);
    check("ldb_wnum", 32'(debug_wb_rf_wnum), 32'd8);
    check("ldb_wdata", debug_wb_rf_wdata, 32'hFFFF_FF80);
    tick();
    mem_resp_valid = 1'b0; mem_resp_data = '0; ra1 = 5'd8; #1;
    check("ldb_rd1", rd1, 32'hFFFF_FF80);

    // LD_HU at addr_lo=2, data arrives immediately
    in_valid = 1'b1; in_wr = mk(1'b1, SRC_MEM, 32'h0, 5'd9);
    in_load_kind = LD_HU; in_addr_lo = 2'd2;
    tick();
    in_valid = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = 32'h80FF_0000; #1;
    check("ldhu_wdata", debug_wb_rf_wdata, 32'h0000_80FF);
    tick();
    mem_resp_valid = 1'b0; ra2 = 5'd9; #1;
    check("ldhu_rd2", rd2, 32'h0000_80FF);

    // Bypass of R3 on both read ports
    ra1 = 5'd3; ra2 = 5'd3;
    in_valid = 1'b1; in_wr = mk(1'b1, SRC_NOP, 32'hDEAD_BEEF, 5'd3); #1;
    check("byp_pre_rd1", rd1, 32'h0);
    tick();
    in_valid = 1'b0; #1;
    check("byp_rd1", rd1, 32'hDEAD_BEEF);
    check("byp_rd2", rd2, 32'hDEAD_BEEF);
    tick();

    // dst=0 is never written
    in_valid = 1'b1; in_wr = mk(1'b1, SRC_NOP, 32'hFFFF_FFFF, 5'd0);
    tick();
    in_valid = 1'b0; ra1 = 5'd0; #1;
    check("r0_wen", 32'(debug_wb_rf_wen), 32'h0);
    check("r0_rd1", rd1, 32'h0);
    tick();

    // Invalid entry to R7 leaves the prior value
    in_valid = 1'b1; in_wr = mk(1'b1, SRC_NOP, 32'h0000_0077, 5'd7);
    tick();
    in_wr = mk(1'b0, SRC_NOP, 32'h0000_0BAD, 5'd7);
    tick();
    in_valid = 1'b0; ra1 = 5'd7; #1;
    check("inv_wen", 32'(debug_wb_rf_wen), 32'h0);
    check("inv_ready", 32'(in_ready), 32'd1);
    check("inv_rd1_commit", rd1, 32'h0000_0077);
    tick();
    check("inv_rd1_after", rd1, 32'h0000_0077);

    // Four back-to-back NOP entries, one commit per cycle
    for (int i = 0; i < 5; i++) begin
      if (i < 4) begin
        in_valid = 1'b1;
        in_wr = mk(1'b1, SRC_NOP, 32'h0000_00A0 + 32'(i), 5'(10 + i));
      end else begin
        in_valid = 1'b0;
      end
      #1;
      check("b2b_ready", 32'(in_ready), 32'd1);
      if (i > 0) begin
        check("b2b_wen", 32'(debug_wb_rf_wen), 32'hF);
        check("b2b_wnum", 32'(debug_wb_rf_wnum), 32'(10 + i - 1));
        check("b2b_wdata", debug_wb_rf_wdata, 32'h0000_00A0 + 32'(i - 1));
      end
      tick();
    end
    check("b2b_idle_wen", 32'(debug_wb_rf_wen), 32'h0);
    ra1 = 5'd10; ra2 = 5'd13; #1;
    check("b2b_rd_r10", rd1, 32'h0000_00A0);
    check("b2b_rd_r13", rd2, 32'h0000_00A3);

    // Reset while a load is outstanding, then a stray response
    in_valid = 1'b1; in_wr = mk(1'b1, SRC_MEM, 32'h0, 5'd14); in_load_kind = LD_W;
    tick();
    in_valid = 1'b0; #1;
    check("rstld_wait_ready", 32'(in_ready), 32'd0);
    resetn = 1'b0; #1;
    check("rstld_ready_in_rst", 32'(in_ready), 32'd0);
    check("rstld_wen_in_rst", 32'(debug_wb_rf_wen), 32'h0);
    tick();
    resetn = 1'b1; mem_resp_valid = 1'b1; mem_resp_data = 32'h1234_5678; #1;
    check("rstld_stray_wen", 32'(debug_wb_rf_wen), 32'h0);
    check("rstld_idle_ready", 32'(in_ready), 32'd1);
    tick();
    mem_resp_valid = 1'b0; ra1 = 5'd14; ra2 = 5'd5; #1;
    check("rstld_r14", rd1, 32'h0);
    check("rstld_r5_cleared", rd2, 32'h0);
    check("rstld_end_wen", 32'(debug_wb_rf_wen), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Writeback stage and general-purpose register file (GPR).
- Consumes the write_reg_t descriptor (valid, src, value, dst) produced at decode and carried down the pipe.
- Resolves the final value from the ALU result, load data, or the precomputed value, commits it into a 32x32 GPR, and serves two combinational read ports with same-cycle bypass to decode.
- Holds the writeback slot while an outstanding load response is pending.

Parameters:
- NUM_REGS, 32, number of GPRs; register 0 is hardwired to zero.
- BYPASS_EN, 1, when 1 the read ports forward the committing value in the same cycle.

Ports:
- clk  in  1  core clock.
- resetn  in  1  synchronous reset, active low.
- in_valid  in  1  upstream offers a writeback entry.
- in_ready  out  1  stage accepts an entry this cycle.
- in_wr  in  write_reg_t  descriptor {valid, src, value, dst}.
- in_alu_result  in  32  ALU result; used when src==SRC_ALU.
- in_load_kind  in  load_kind_t  LD_B/LD_BU/LD_H/LD_HU/LD_W; meaningful when src==SRC_MEM.
- in_addr_lo  in  2  low address bits of the load.
- in_pc  in  32  PC of the entry, for debug trace.
- mem_resp_valid  in  1  load data valid this cycle.
- mem_resp_data  in  32  raw aligned load word.
- ra1, ra2  in  5  read addresses.
- rd1, rd2  out  32  read data.
- debug_wb_pc  out  32  PC of the committing entry.
- debug_wb_rf_wen  out  4  4'hF on a GPR write, else 0.
- debug_wb_rf_wnum  out  5  destination register.
- debug_wb_rf_wdata  out  32  written value.

Behaviour:
- States:
  - IDLE: no entry held.
  - HOLD: entry held, value ready.
  - WAIT_MEM: entry held, src==SRC_MEM, no data yet.
- Accept: on in_valid && in_ready, latch in_wr, in_alu_result, load kind, in_addr_lo and in_pc. Next state is WAIT_MEM if in_wr.src==SRC_MEM, else HOLD.
- commit_now = (state==HOLD) || (state==WAIT_MEM && mem_resp_valid).
- in_ready = (state==IDLE) || commit_now. A back-to-back accept and commit in the same cycle is legal, giving one entry per cycle.
- If commit_now and no accept, next state is IDLE.
- In WAIT_MEM without mem_resp_valid: stay, in_ready=0.
- mem_resp_valid outside WAIT_MEM is ignored.
- Value select:
  - SRC_ALU gives the latched ALU result.
  - SRC_NOP gives the latched in_wr.value (covers MFHI/MFLO/MFC0/MTC0).
  - SRC_MEM gives the extracted load value:
    - byte = word >> (8*addr_lo); half = word >> (16*addr_lo[1]).
    - LD_B / LD_BU: sign- / zero-extend 8 bits.
    - LD_H / LD_HU: sign- / zero-extend 16 bits.
    - LD_W: word unchanged; addr_lo is ignored.
- GPR write: at the clock edge ending a commit_now cycle, only if wr.valid && dst!=0.
  - wr.valid=0: the entry is consumed and debug_wb_rf_wen=0.
  - dst==0: no write and debug_wb_rf_wen=0, even if wr.valid.
- Debug outputs are combinational from the committing entry and are valid only when commit_now; otherwise debug_wb_rf_wen=0.
- Reads are combinational:
  - rdN = 0 if raN==0.
  - If BYPASS_EN, raN==dst and the write fires this cycle: the commit value.
  - Otherwise: array contents.
- Reset (resetn low at a clock edge):
  - state goes to IDLE and the held entry is dropped, including mid-WAIT_MEM.
  - All GPRs clear to 0.
  - in_ready=0 while resetn is low; debug_wb_rf_wen=0.
  - A mem_resp_valid arriving in the first cycle after reset is ignored.

Decomposition:
- Shared package mycpu.svh holds:
  - write_reg_t and the src enum (SRC_NOP/SRC_ALU/SRC_MEM);
  - new load_kind_t enum (3 bits);
  - wb_state_t enum.
- Sub-module load_extract: purely combinational; (word, addr_lo, kind) in, 32-bit value out.
- GPR array, FSM and bypass logic remain in wb_regfile.

Test Plan:
- Reset then ALU write: entry {valid=1, src=SRC_ALU, dst=5} with alu=32'h1234_5678.
  - Next cycle rf_wen=4'hF, wnum=5.
  - Then ra1=5 gives rd1=32'h1234_5678.
- Load with delayed data: entry {SRC_MEM, dst=8, LD_B, addr_lo=2'd3}.
  - in_ready=0 for 3 cycles.
  - mem_resp_data=32'h80FF_0000 then gives R8=32'hFFFF_FF80.
  - Same word with LD_HU and addr_lo=2 gives 32'h0000_80FF.
- Bypass: commit to R3=32'hDEAD_BEEF while ra1=ra2=3 in the same cycle.
  - rd1=rd2=32'hDEAD_BEEF in that cycle.
- Register 0 and invalid descriptors: entry dst=0 with value 32'hFFFF_FFFF gives rd(0)=0 and rf_wen=0.
  - Entry valid=0, dst=7 leaves R7 unchanged and is consumed in one cycle.
- Back-to-back with reset mid-load:
  - 4 consecutive SRC_NOP entries each commit one per cycle with in_ready=1 throughout.
  - A load in WAIT_MEM, then resetn=0 for one cycle, then mem_resp_valid, gives no write and the state returns to IDLE.
